seq_hit_counter: RTL
====================

// Module: seq_hit_counter
// PURPOSE
//  Downstream consumer of the serial "11" sequence detector output. Counts detector
//  hits over fixed windows of WIN clocks. Hands each window's count to the next stage
//  over a valid/ready handshake. Flags lost reports and saturated counts.
// PARAMETERS
//  CW   8   width of hit accumulator and reported count
//  WIN  16  window length in clock cycles (>=2)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   reset, asynchronous, active-low
//  hit        in   1   detector output, sampled every clk
//  clr        in   1   synchronous clear, highest priority after rst_n
//  cnt_out    out  CW  reported hit count of last completed window
//  cnt_sat    out  1   reported count saturated (accompanies cnt_out)
//  cnt_valid  out  1   report pending
//  cnt_ready  in   1   consumer accepts report when cnt_valid&&cnt_ready
//  ovf        out  1   sticky: a report was dropped because previous one was unaccepted
// BEHAVIOUR
//  - Reset (rst_n=0, async): cnt_out=0, cnt_sat=0, cnt_valid=0, ovf=0, acc=0, wcnt=0.
//  - clr=1 at edge: same values as reset, except ovf also cleared; ignores hit that cycle.
//  - wcnt free-runs 0..WIN-1, wraps to 0; win_end = (wcnt==WIN-1).
//  - Each edge with inc=1: acc+=1, saturating at 2^CW-1; sat_acc sets when increment is blocked.
//  - At win_end edge: report <= acc+inc (saturated), cnt_sat <= sat_acc|blocked-inc;
//    acc<=0, sat_acc<=0. Next window starts with next cycle's hit.
//  - Latency: cnt_valid rises the cycle after the win_end edge; it includes the win_end cycle's hit.
//  - Report FSM, two states:
//    EMPTY: cnt_valid=0; win_end -> FULL (load report).
//    FULL: cnt_valid=1; accept with no win_end -> EMPTY;
//      win_end with accept same edge -> FULL, new report loaded, no ovf;
//      win_end without accept -> FULL, old report kept, new one dropped, ovf<=1.
//  - cnt_out/cnt_sat stable while cnt_valid=1 and not accepted.
//  - ovf stays 1 until clr or rst_n.
//  - rst_n deasserted mid-window: window restarts at wcnt=0. No partial report is produced.
// CONFIGURATION
//  SEQ_HIT_EDGE_EN defined: inc = hit & ~hit_d.
//    hit_d is a one-cycle delay of hit; reset/clr set it to 0.
//    A run of back-to-back hits counts once.
//  Not defined: inc = hit; every high cycle counts as one hit (overlapping detections).
// STRUCTURE
//  seq_pkg: report-state enum (EMPTY/FULL), default CW/WIN localparams.
//  Sub-module seq_win_timer: wcnt register and win_end strobe, params WIN; has clk/rst_n/clr.
//  Top: accumulator, saturation, report FSM, ovf, optional edge detector.
// TESTING (WIN=16, CW=8 unless stated; ready=1 unless stated)
//  1 hit=1 for all 16 cycles of a window -> cnt_out=16, cnt_sat=0, cnt_valid 1 cycle;
//    with SEQ_HIT_EDGE_EN -> cnt_out=1.
//  2 hit=1,0,1,0... over a window -> cnt_out=8 in both configurations.
//  3 ready=0 across two win_end edges (counts 5 then 9) -> cnt_out stays 5, ovf=1;
//    ready=1 -> accept, cnt_valid=0 next cycle.
//  4 win_end and accept on the same edge (counts 3 then 7) -> cnt_valid stays 1, cnt_out=7, ovf=0.
//  5 CW=4, hit=1 for a full window -> cnt_out=15, cnt_sat=1. Next window with 2 hits -> cnt_out=2, cnt_sat=0.
//  6 clr at wcnt=5 with 4 hits so far -> report of that window never appears,
//    next cnt_valid 16 cycles after clr, ovf=0. rst_n pulse mid-window -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/seq_hit_counter_pkg.sv
// Shared types and defaults for the windowed hit counter.
// The report FSM state encoding and default CW/WIN live here.
package seq_hit_counter_pkg;

  typedef enum logic {
    RPT_EMPTY = 1'b0,
    RPT_FULL  = 1'b1
  } rpt_state_e;

  localparam int DEF_CW  = 8;
  localparam int DEF_WIN = 16;

endpackage

// File: rtl/seq_hit_counter_if.sv
// Report handshake bundle: the counter drives count/sat/valid and the consumer drives ready.
interface seq_hit_counter_if
  import seq_hit_counter_pkg::*;
#(
  parameter int CW = DEF_CW
);

  logic [CW-1:0] cnt_out;
  logic          cnt_sat;
  logic          cnt_valid;
  logic          cnt_ready;

  modport master (output cnt_out, cnt_sat, cnt_valid, input cnt_ready);
  modport slave  (input cnt_out, cnt_sat, cnt_valid, output cnt_ready);

endinterface

// File: rtl/seq_hit_counter_win_timer.sv
// Free-running window timer: wcnt counts 0..WIN-1 and win_end marks the last cycle.
module seq_win_timer
  import seq_hit_counter_pkg::*;
#(
  parameter int WIN = DEF_WIN
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic win_end
);

  localparam int             WW   = $clog2(WIN);
  localparam logic [WW-1:0]  LAST = WW'(WIN - 1);

  logic [WW-1:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (wcnt == LAST) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WW'(1);
    end
  end

  assign win_end = (wcnt == LAST);

endmodule

// File: rtl/seq_hit_counter.sv
// Counts detector hits per WIN-cycle window and reports each window over valid/ready.
// Define SEQ_HIT_EDGE_EN to count only rising edges of hit (a run of hits counts once).
module seq_hit_counter
  import seq_hit_counter_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int WIN = DEF_WIN
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              clr,
  output logic              ovf,
  seq_hit_counter_if.master rpt
);

  logic          win_end;
  logic          inc;
  logic          blocked;
  logic          sat_acc;
  logic          accept;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_next;
  rpt_state_e    state;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] a, input logic b);
    return (b && (a != {CW{1'b1}})) ? a + CW'(1) : a;
  endfunction

  seq_win_timer #(.WIN(WIN)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .win_end (win_end)
  );

`ifdef SEQ_HIT_EDGE_EN
  logic hit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_d <= 1'b0;
    end else if (clr) begin
      hit_d <= 1'b0;
    end else begin
      hit_d <= hit;
    end
  end

  assign inc = hit & ~hit_d;
`else
  assign inc = hit;
`endif

  assign blocked  = inc & (acc == {CW{1'b1}});
  assign acc_next = sat_inc(acc, inc);
  assign accept   = rpt.cnt_valid & rpt.cnt_ready;

  // The window-end cycle's hit is folded into the report, and the next window starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (clr || win_end) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else begin
      acc     <= acc_next;
      sat_acc <= sat_acc | blocked;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RPT_EMPTY;
      rpt.cnt_out   <= '0;
      rpt.cnt_sat   <= 1'b0;
      rpt.cnt_valid <= 1'b0;
      ovf           <= 1'b0;
    end else if (clr) begin
      state         <= RPT_EMPTY;
      rpt.cnt_out   <= '0;
      rpt.cnt_sat   <= 1'b0;
      rpt.cnt_valid <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      case (state)
        RPT_EMPTY: begin
          if (win_end) begin
            state         <= RPT_FULL;
            rpt.cnt_out   <= acc_next;
            rpt.cnt_sat   <= sat_acc | blocked;
            rpt.cnt_valid <= 1'b1;
          end
        end
        RPT_FULL: begin
          // An unaccepted report is never overwritten; the newer one is the one lost.
          if (win_end && accept) begin
            rpt.cnt_out <= acc_next;
            rpt.cnt_sat <= sat_acc | blocked;
          end else if (win_end) begin
            ovf <= 1'b1;
          end else if (accept) begin
            state         <= RPT_EMPTY;
            rpt.cnt_valid <= 1'b0;
          end
        end
        default: begin
          state         <= RPT_EMPTY;
          rpt.cnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
